// File: rtl/pipe_execute_mc.sv
// pipe_execute_mc: Y86 execute stage with E->M pipeline register.
// Single-cycle ALU/address arithmetic, exception-gated condition codes,
// M bubble insertion and an iterative shift-add multiplier (OPq ifun 4)
// that stalls the front of the pipe through e_busy while it runs.
module pipe_execute_mc #(
    parameter int WIDTH      = 64,
    parameter int STACK_STEP = 8,
    parameter int MUL_EN     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       E_stat,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_ifun,
    input  logic [WIDTH-1:0] E_valC,
    input  logic [WIDTH-1:0] E_valA,
    input  logic [WIDTH-1:0] E_valB,
    input  logic [3:0]       E_dstE,
    input  logic [3:0]       E_dstM,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_stat,
    input  logic             M_bubble,
    output logic [WIDTH-1:0] e_valE,
    output logic [3:0]       e_dstE,
    output logic             e_cnd,
    output logic             e_busy,
    output logic [3:0]       M_stat,
    output logic [3:0]       M_icode,
    output logic             M_cnd,
    output logic [WIDTH-1:0] M_valE,
    output logic [WIDTH-1:0] M_valA,
    output logic [3:0]       M_dstE,
    output logic [3:0]       M_dstM,
    output logic [2:0]       cc
);

    localparam int               CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] STEP     = WIDTH'(STACK_STEP);
    localparam logic [3:0]       STAT_AOK = 4'h1;
    localparam logic [3:0]       REG_NONE = 4'hF;
    localparam logic [3:0]       I_NOP    = 4'h1;
    localparam logic [3:0]       I_OPQ    = 4'h6;
    localparam logic [3:0]       F_MUL    = 4'h4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_cc;

    logic [3:0]       r_m_stat;
    logic [3:0]       r_m_icode;
    logic             r_m_cnd;
    logic [WIDTH-1:0] r_m_vale;
    logic [WIDTH-1:0] r_m_vala;
    logic [3:0]       r_m_dste;
    logic [3:0]       r_m_dstm;

    logic             w_start;
    logic             w_busy_fsm;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_of;
    logic             w_of;
    logic             w_sf;
    logic             w_zf;
    logic             w_lt;
    logic             w_cnd;
    logic [WIDTH-1:0] w_vale;
    logic             w_cc_we;
    logic             w_load_bubble;

    assign w_start = (E_icode == I_OPQ) && (E_ifun == F_MUL) &&
                     (E_stat == STAT_AOK) && (MUL_EN != 0);
    assign w_sum   = E_valB + E_valA;
    assign w_diff  = E_valB - E_valA;

    // ALU: result and signed overflow for the selected OPq function
    always_comb begin
        w_alu_res = '0;
        w_alu_of  = 1'b0;
        case (E_ifun)
            4'h0: begin
                w_alu_res = w_sum;
                w_alu_of  = (E_valA[WIDTH-1] == E_valB[WIDTH-1]) &&
                            (w_sum[WIDTH-1] != E_valA[WIDTH-1]);
            end
            4'h1: begin
                w_alu_res = w_diff;
                w_alu_of  = (E_valA[WIDTH-1] != E_valB[WIDTH-1]) &&
                            (w_diff[WIDTH-1] != E_valB[WIDTH-1]);
            end
            4'h2: w_alu_res = E_valA & E_valB;
            4'h3: w_alu_res = E_valA ^ E_valB;
            // The product is only valid in DONE; a multiply that never
            // started (bad status or disabled) falls through as zero.
            4'h4: if ((MUL_EN != 0) && (r_state == S_DONE)) w_alu_res = r_acc;
            default: w_alu_res = '0;
        endcase
    end

    // valE selection by instruction class
    always_comb begin
        w_vale = '0;
        case (E_icode)
            4'h2:       w_vale = E_valA;
            4'h3:       w_vale = E_valC;
            4'h4, 4'h5: w_vale = E_valB + E_valC;
            4'h6:       w_vale = w_alu_res;
            4'h8, 4'hA: w_vale = E_valB - STEP;
            4'h9, 4'hB: w_vale = E_valB + STEP;
            default:    w_vale = '0;
        endcase
    end

    assign w_of = r_cc[2];
    assign w_sf = r_cc[1];
    assign w_zf = r_cc[0];
    assign w_lt = w_sf ^ w_of;

    // Branch/cmov condition from the stored condition codes
    always_comb begin
        w_cnd = 1'b0;
        case (E_ifun)
            4'h0:    w_cnd = 1'b1;
            4'h1:    w_cnd = w_lt | w_zf;
            4'h2:    w_cnd = w_lt;
            4'h3:    w_cnd = w_zf;
            4'h4:    w_cnd = !w_zf;
            4'h5:    w_cnd = !w_lt;
            4'h6:    w_cnd = !(w_lt | w_zf);
            default: w_cnd = 1'b0;
        endcase
    end

    // Multiply FSM next state; busy is raised already in the capture cycle
    always_comb begin
        w_state_next = r_state;
        w_busy_fsm   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_busy_fsm   = 1'b1;
                    w_state_next = S_MUL;
                end
            end
            S_MUL: begin
                w_busy_fsm = 1'b1;
                if (r_cnt == CNT_LAST) w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Held in reset the stage must not report busy even with a multiply on E
    assign e_busy        = w_busy_fsm & rst_n;
    assign e_valE        = w_vale;
    assign e_cnd         = w_cnd;
    assign e_dstE        = ((E_icode == 4'h2) && !w_cnd) ? REG_NONE : E_dstE;
    assign w_load_bubble = e_busy | M_bubble;
    assign w_cc_we       = !e_busy && !M_bubble && (E_icode == I_OPQ) &&
                           (E_stat == STAT_AOK) && (m_stat == STAT_AOK) &&
                           (W_stat == STAT_AOK);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Shift-add multiplier datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_start) begin
                r_mcand  <= E_valA;
                r_mplier <= E_valB;
                r_acc    <= '0;
                r_cnt    <= '0;
            end
        end else if (r_state == S_MUL) begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    // Condition codes {OF, SF, ZF}, written only by committed OPq results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_cc <= 3'b001;
        else if (w_cc_we) r_cc <= {w_alu_of, w_alu_res[WIDTH-1], (w_alu_res == '0)};
    end

    // E->M pipeline register with bubble insertion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_stat  <= STAT_AOK;
            r_m_icode <= I_NOP;
            r_m_cnd   <= 1'b0;
            r_m_vale  <= '0;
            r_m_vala  <= '0;
            r_m_dste  <= REG_NONE;
            r_m_dstm  <= REG_NONE;
        end else if (w_load_bubble) begin
            r_m_stat  <= STAT_AOK;
            r_m_icode <= I_NOP;
            r_m_cnd   <= 1'b0;
            r_m_vale  <= '0;
            r_m_vala  <= '0;
            r_m_dste  <= REG_NONE;
            r_m_dstm  <= REG_NONE;
        end else begin
            r_m_stat  <= E_stat;
            r_m_icode <= E_icode;
            r_m_cnd   <= w_cnd;
            r_m_vale  <= w_vale;
            r_m_vala  <= E_valA;
            r_m_dste  <= e_dstE;
            r_m_dstm  <= E_dstM;
        end
    end

    assign M_stat  = r_m_stat;
    assign M_icode = r_m_icode;
    assign M_cnd   = r_m_cnd;
    assign M_valE  = r_m_vale;
    assign M_valA  = r_m_vala;
    assign M_dstE  = r_m_dste;
    assign M_dstM  = r_m_dstm;
    assign cc      = r_cc;

endmodule

// File: tb/tb_pipe_execute_mc.sv
// Bench for pipe_execute_mc (WIDTH=64): directed vector table, random
// single-cycle traffic against a reference model, and multiply sequences.
module tb_pipe_execute_mc;

    localparam int W = 64;

    logic         clk;
    logic         rst_n;
    logic [3:0]   E_stat, E_icode, E_ifun, E_dstE, E_dstM, m_stat, W_stat;
    logic [W-1:0] E_valC, E_valA, E_valB;
    logic         M_bubble;
    logic [W-1:0] e_valE, M_valE, M_valA;
    logic [3:0]   e_dstE, M_stat, M_icode, M_dstE, M_dstM;
    logic         e_cnd, e_busy, M_cnd;
    logic [2:0]   cc;

    int checks = 0;
    int errors = 0;
    logic [2:0] m_cc;

    typedef struct {
        logic [3:0]  st, ic, fn;
        logic [63:0] a, b, c;
        logic [3:0]  de, dm, ms, ws;
        logic        mb;
        logic [63:0] ev;
        logic        ec;
        logic [3:0]  ed;
        logic [2:0]  ecc;
    } vec_t;

    vec_t tbl[19];

    pipe_execute_mc #(.WIDTH(W), .STACK_STEP(8), .MUL_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .m_stat(m_stat), .W_stat(W_stat),
        .M_bubble(M_bubble),
        .e_valE(e_valE), .e_dstE(e_dstE), .e_cnd(e_cnd), .e_busy(e_busy),
        .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .cc(cc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] st, ic, fn, input logic [63:0] a, b, c,
                                input logic [3:0] de, dm, ms, ws, input logic mb,
                                input logic [63:0] ev, input logic ec, input logic [3:0] ed,
                                input logic [2:0] ecc);
        vec_t v;
        v.st = st; v.ic = ic; v.fn = fn; v.a = a; v.b = b; v.c = c;
        v.de = de; v.dm = dm; v.ms = ms; v.ws = ws; v.mb = mb;
        v.ev = ev; v.ec = ec; v.ed = ed; v.ecc = ecc;
        return v;
    endfunction

    // Reference model: plain signed arithmetic on 65-bit values for overflow
    function automatic vec_t ref_fill(input vec_t v, input logic [2:0] ccin);
        vec_t        o;
        logic [64:0] wide;
        logic [63:0] r;
        logic        of, lt, eq;
        o = v; r = '0; of = 1'b0; wide = '0;
        case (v.fn)
            4'h0: begin wide = {v.a[63], v.a} + {v.b[63], v.b}; r = wide[63:0]; of = wide[64] ^ wide[63]; end
            4'h1: begin wide = {v.b[63], v.b} - {v.a[63], v.a}; r = wide[63:0]; of = wide[64] ^ wide[63]; end
            4'h2: r = v.a & v.b;
            4'h3: r = v.a ^ v.b;
            default: r = '0;
        endcase
        lt = ccin[1] ^ ccin[2];
        eq = ccin[0];
        case (v.fn)
            4'h0: o.ec = 1'b1;
            4'h1: o.ec = lt | eq;
            4'h2: o.ec = lt;
            4'h3: o.ec = eq;
            4'h4: o.ec = !eq;
            4'h5: o.ec = !lt;
            4'h6: o.ec = !(lt | eq);
            default: o.ec = 1'b0;
        endcase
        case (v.ic)
            4'h2: o.ev = v.a;
            4'h3: o.ev = v.c;
            4'h4, 4'h5: o.ev = v.b + v.c;
            4'h6: o.ev = r;
            4'h8, 4'hA: o.ev = v.b - 64'd8;
            4'h9, 4'hB: o.ev = v.b + 64'd8;
            default: o.ev = '0;
        endcase
        o.ed = (v.ic == 4'h2 && !o.ec) ? 4'hF : v.de;
        if (v.ic == 4'h6 && v.st == 4'h1 && v.ms == 4'h1 && v.ws == 4'h1 && !v.mb)
            o.ecc = {of, r[63], (r == 64'd0)};
        else
            o.ecc = ccin;
        return o;
    endfunction

    task automatic drive(input vec_t v);
        E_stat = v.st; E_icode = v.ic; E_ifun = v.fn;
        E_valA = v.a; E_valB = v.b; E_valC = v.c;
        E_dstE = v.de; E_dstM = v.dm; m_stat = v.ms; W_stat = v.ws;
        M_bubble = v.mb;
    endtask

    // One single-cycle transaction: combinational outputs, then M and cc
    task automatic tx(input vec_t v, input string nm);
        drive(v);
        #1;
        chk({nm, "_e_valE"}, e_valE, v.ev);
        chk({nm, "_e_cnd"}, {63'd0, e_cnd}, {63'd0, v.ec});
        chk({nm, "_e_dstE"}, {60'd0, e_dstE}, {60'd0, v.ed});
        chk({nm, "_e_busy"}, {63'd0, e_busy}, 64'd0);
        @(posedge clk); #1;
        if (v.mb) begin
            chk({nm, "_M_stat"}, {60'd0, M_stat}, 64'h1);
            chk({nm, "_M_icode"}, {60'd0, M_icode}, 64'h1);
            chk({nm, "_M_cnd"}, {63'd0, M_cnd}, 64'h0);
            chk({nm, "_M_valE"}, M_valE, 64'h0);
            chk({nm, "_M_valA"}, M_valA, 64'h0);
            chk({nm, "_M_dstE"}, {60'd0, M_dstE}, 64'hF);
            chk({nm, "_M_dstM"}, {60'd0, M_dstM}, 64'hF);
        end else begin
            chk({nm, "_M_stat"}, {60'd0, M_stat}, {60'd0, v.st});
            chk({nm, "_M_icode"}, {60'd0, M_icode}, {60'd0, v.ic});
            chk({nm, "_M_cnd"}, {63'd0, M_cnd}, {63'd0, v.ec});
            chk({nm, "_M_valE"}, M_valE, v.ev);
            chk({nm, "_M_valA"}, M_valA, v.a);
            chk({nm, "_M_dstE"}, {60'd0, M_dstE}, {60'd0, v.ed});
            chk({nm, "_M_dstM"}, {60'd0, M_dstM}, {60'd0, v.dm});
        end
        chk({nm, "_cc"}, {61'd0, cc}, {61'd0, v.ecc});
        $display("%s icode=%h ifun=%h bub=%0d valE=%h cc=%b", nm, v.ic, v.fn, v.mb, e_valE, cc);
    endtask

    // Full multiply: busy length, bubbles into M, then the product and cc
    task automatic run_mul(input logic [63:0] a, input logic [63:0] b, input string nm);
        logic [63:0] prod;
        int busy_n, bad_bub;
        prod = a * b;
        drive(mk(4'h1, 4'h6, 4'h4, a, b, 64'd0, 4'h2, 4'hF, 4'h1, 4'h1, 1'b0, 0, 0, 0, 0));
        #1;
        busy_n = 0; bad_bub = 0;
        for (int k = 0; k < W + 20; k++) begin
            if (!e_busy) break;
            busy_n++;
            @(posedge clk); #1;
            if (M_icode !== 4'h1 || M_dstE !== 4'hF || M_valE !== 64'd0 || M_stat !== 4'h1) bad_bub++;
        end
        chk({nm, "_busy_cycles"}, 64'(busy_n), 64'(W + 1));
        chk({nm, "_bubbles"}, 64'(bad_bub), 64'd0);
        chk({nm, "_done_e_valE"}, e_valE, prod);
        @(posedge clk); #1;
        chk({nm, "_M_valE"}, M_valE, prod);
        chk({nm, "_M_icode"}, {60'd0, M_icode}, 64'h6);
        chk({nm, "_cc"}, {61'd0, cc}, {61'd0, 1'b0, prod[63], (prod == 64'd0)});
        m_cc = {1'b0, prod[63], (prod == 64'd0)};
        $display("%s a=%h b=%h busy=%0d M_valE=%h cc=%b", nm, a, b, busy_n, M_valE, cc);
    endtask

    initial begin
        vec_t v;
        logic [63:0] ra, rb;

        tbl[0]  = mk(4'h1, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'h2, 4'hF, 4'h1, 4'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 4'h2, 3'b110);
        tbl[1]  = mk(4'h1, 4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h4, 4'hF, 4'h1, 4'h1, 1'b0, 64'd0, 1'b0, 4'h4, 3'b001);
        tbl[2]  = mk(4'h1, 4'h2, 4'h4, 64'h1234, 64'd0, 64'd0, 4'h3, 4'hF, 4'h1, 4'h1, 1'b0, 64'h1234, 1'b0, 4'hF, 3'b001);
        tbl[3]  = mk(4'h1, 4'h2, 4'h3, 64'h55, 64'd0, 64'd0, 4'h3, 4'hF, 4'h1, 4'h1, 1'b0, 64'h55, 1'b1, 4'h3, 3'b001);
        tbl[4]  = mk(4'h1, 4'h6, 4'h1, 64'd1, 64'd3, 64'd0, 4'h7, 4'hF, 4'h3, 4'h1, 1'b0, 64'd2, 1'b1, 4'h7, 3'b001);
        tbl[5]  = mk(4'h1, 4'hA, 4'h0, 64'h77, 64'h100, 64'd0, 4'h4, 4'hF, 4'h1, 4'h1, 1'b0, 64'hF8, 1'b1, 4'h4, 3'b001);
        tbl[6]  = mk(4'h1, 4'hB, 4'h0, 64'd0, 64'hF8, 64'd0, 4'h4, 4'h6, 4'h1, 4'h1, 1'b1, 64'h100, 1'b1, 4'h4, 3'b001);
        tbl[7]  = mk(4'h1, 4'h6, 4'h1, 64'd3, 64'd1, 64'd0, 4'h1, 4'hF, 4'h1, 4'h1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 4'h1, 3'b010);
        tbl[8]  = mk(4'h1, 4'h6, 4'h3, 64'hF0, 64'hF0, 64'd0, 4'h2, 4'hF, 4'h1, 4'h1, 1'b0, 64'd0, 1'b0, 4'h2, 3'b001);
        tbl[9]  = mk(4'h1, 4'h6, 4'h2, 64'hFF00, 64'h0FF0, 64'd0, 4'h2, 4'hF, 4'h1, 4'h1, 1'b0, 64'h0F00, 1'b0, 4'h2, 3'b000);
        tbl[10] = mk(4'h1, 4'h5, 4'h0, 64'hAB, 64'h10, 64'h20, 4'hF, 4'h3, 4'h1, 4'h1, 1'b0, 64'h30, 1'b1, 4'hF, 3'b000);
        tbl[11] = mk(4'h1, 4'h3, 4'h0, 64'd0, 64'd0, 64'hDEAD, 4'h5, 4'hF, 4'h1, 4'h1, 1'b0, 64'hDEAD, 1'b1, 4'h5, 3'b000);
        tbl[12] = mk(4'h1, 4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 4'h6, 4'hF, 4'h1, 4'h1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 4'h6, 3'b100);
        tbl[13] = mk(4'h3, 4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h6, 4'hF, 4'h1, 4'h1, 1'b0, 64'd2, 1'b1, 4'h6, 3'b100);
        tbl[14] = mk(4'h1, 4'h2, 4'h2, 64'h99, 64'd0, 64'd0, 4'h5, 4'hF, 4'h1, 4'h1, 1'b0, 64'h99, 1'b1, 4'h5, 3'b100);
        tbl[15] = mk(4'h1, 4'h2, 4'h6, 64'h98, 64'd0, 64'd0, 4'h5, 4'hF, 4'h1, 4'h1, 1'b0, 64'h98, 1'b0, 4'hF, 3'b100);
        tbl[16] = mk(4'h1, 4'h7, 4'h1, 64'd0, 64'd0, 64'h400, 4'hF, 4'hF, 4'h1, 4'h1, 1'b0, 64'd0, 1'b1, 4'hF, 3'b100);
        tbl[17] = mk(4'h1, 4'h6, 4'h0, 64'd0, 64'd0, 64'd0, 4'h1, 4'hF, 4'h1, 4'h2, 1'b0, 64'd0, 1'b1, 4'h1, 3'b100);
        tbl[18] = mk(4'h1, 4'h6, 4'h7, 64'd9, 64'd9, 64'd0, 4'h1, 4'hF, 4'h1, 4'h1, 1'b0, 64'd0, 1'b0, 4'h1, 3'b001);

        // Reset state
        rst_n = 1'b0;
        drive(mk(4'h1, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 4'h1, 4'h1, 1'b0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        chk("rst_M_icode", {60'd0, M_icode}, 64'h1);
        chk("rst_M_dstE", {60'd0, M_dstE}, 64'hF);
        chk("rst_M_dstM", {60'd0, M_dstM}, 64'hF);
        chk("rst_cc", {61'd0, cc}, 64'h1);
        chk("rst_busy", {63'd0, e_busy}, 64'd0);
        $display("reset M_icode=%h cc=%b", M_icode, cc);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 19; i++) tx(tbl[i], $sformatf("vec%0d", i));
        m_cc = tbl[18].ecc;

        // Random single-cycle traffic against the model
        for (int i = 0; i < 150; i++) begin
            v.ic = ($urandom_range(0, 2) == 0) ? 4'h6 : 4'($urandom_range(0, 15));
            v.fn = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) v.fn = 4'($urandom_range(0, 3));
            v.st = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(2, 4)) : 4'h1;
            v.ms = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(2, 4)) : 4'h1;
            v.ws = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(2, 4)) : 4'h1;
            if (v.ic == 4'h6 && v.fn == 4'h4 && v.st == 4'h1) v.fn = 4'h5;
            v.a = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 16)) : {$urandom(), $urandom()};
            v.b = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 16)) : {$urandom(), $urandom()};
            if ($urandom_range(0, 5) == 0) v.b = v.a;
            v.c = {$urandom(), $urandom()};
            v.de = 4'($urandom_range(0, 15));
            v.dm = 4'($urandom_range(0, 15));
            v.mb = ($urandom_range(0, 7) == 0);
            v = ref_fill(v, m_cc);
            tx(v, $sformatf("rnd%0d", i));
            m_cc = v.ecc;
        end

        // Multiply with a bad status passes through in one cycle as zero
        v = mk(4'h3, 4'h6, 4'h4, 64'd7, 64'd5, 64'd0, 4'h2, 4'hF, 4'h1, 4'h1, 1'b0, 0, 0, 0, 0);
        v = ref_fill(v, m_cc);
        tx(v, "mul_badstat");
        m_cc = v.ecc;

        // Multiply, back-to-back entry, random operands
        run_mul(64'd7, 64'hFFFF_FFFF_FFFF_FFFD, "mul_7xm3");
        chk("mul_backtoback_busy", {63'd0, e_busy}, 64'd1);
        run_mul(64'd7, 64'hFFFF_FFFF_FFFF_FFFD, "mul_again");
        for (int i = 0; i < 2; i++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            run_mul(ra, rb, $sformatf("mul_rnd%0d", i));
        end

        // Bubble while in DONE discards the product
        drive(mk(4'h1, 4'h6, 4'h4, 64'd3, 64'd4, 64'd0, 4'h2, 4'hF, 4'h1, 4'h1, 1'b0, 0, 0, 0, 0));
        #1;
        for (int k = 0; k < W + 20; k++) begin
            if (!e_busy) break;
            @(posedge clk); #1;
        end
        chk("bubdone_not_busy", {63'd0, e_busy}, 64'd0);
        M_bubble = 1'b1;
        #1;
        @(posedge clk); #1;
        chk("bubdone_M_icode", {60'd0, M_icode}, 64'h1);
        chk("bubdone_M_valE", M_valE, 64'd0);
        chk("bubdone_cc", {61'd0, cc}, {61'd0, m_cc});
        drive(mk(4'h1, 4'h3, 4'h0, 64'd0, 64'd0, 64'h77, 4'h2, 4'hF, 4'h1, 4'h1, 1'b0, 0, 0, 0, 0));
        #1;
        chk("bubdone_idle_busy", {63'd0, e_busy}, 64'd0);
        chk("bubdone_idle_valE", e_valE, 64'h77);
        $display("bubble_in_done M_icode=%h cc=%b", M_icode, cc);

        // Reset in the middle of a multiply
        drive(mk(4'h1, 4'h6, 4'h4, 64'd5, 64'd9, 64'd0, 4'h2, 4'hF, 4'h1, 4'h1, 1'b0, 0, 0, 0, 0));
        #1;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_busy_before", {63'd0, e_busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {63'd0, e_busy}, 64'd0);
        chk("midrst_M_icode", {60'd0, M_icode}, 64'h1);
        chk("midrst_M_dstE", {60'd0, M_dstE}, 64'hF);
        chk("midrst_M_dstM", {60'd0, M_dstM}, 64'hF);
        chk("midrst_cc", {61'd0, cc}, 64'h1);
        $display("reset_mid_mul busy=%0d M_icode=%h cc=%b", e_busy, M_icode, cc);
        m_cc = 3'b001;
        @(negedge clk) rst_n = 1'b1;
        run_mul(64'd5, 64'd9, "mul_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
